gba_bk_sync: RTL and testbench



---
 rtl/gba_bk_pkg.sv | 20 ++
 rtl/bk_sector_buf.sv | 52 +++++
 rtl/gba_bk_sync.sv | 206 ++++++++++++++++++++
 tb/tb_gba_bk_sync.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gba_bk_pkg.sv
// Shared definitions for the GBA backup-RAM sync engine.
// Contents: the engine FSM state type and the fixed sector geometry
// (one 512-byte save-file sector = 128 SDRAM dwords = 256 HPS half-words).
package gba_bk_pkg;

  localparam int SECTOR_DWORDS = 128;
  localparam int SECTOR_BYTES  = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_REQ,
    ST_LD_XFER,
    ST_LD_COPY,
    ST_SV_FILL,
    ST_SV_REQ,
    ST_SV_XFER,
    ST_NEXT
  } bk_state_t;

endpackage

// File: rtl/bk_sector_buf.sv
// One-sector staging buffer, 128 x 32-bit, between the HPS and SDRAM sides.
// Ports:
//   clk_sys, reset        clock, synchronous active-high reset (read regs only)
//   i_a_addr/i_a_wdata/   HPS side: 16-bit half-word index, write data,
//   i_a_we/o_a_rdata      write enable, registered 16-bit read (1-cycle latency)
//   i_b_addr/i_b_wdata/   SDRAM side: dword index, 32-bit write data,
//   i_b_we/o_b_rdata      write enable, registered 32-bit read (1-cycle latency)
module bk_sector_buf (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [7:0]  i_a_addr,
  input  logic [15:0] i_a_wdata,
  input  logic        i_a_we,
  output logic [15:0] o_a_rdata,
  input  logic [6:0]  i_b_addr,
  input  logic [31:0] i_b_wdata,
  input  logic        i_b_we,
  output logic [31:0] o_b_rdata
);

  logic [31:0] r_mem [0:127];
  logic [31:0] r_a_q;
  logic        r_a_hi;
  logic [31:0] r_b_q;

  // Both sides write in mutually exclusive engine states, so one write
  // process covers them; half-word index bit 0 selects the upper half.
  always_ff @(posedge clk_sys) begin
    if (i_b_we)
      r_mem[i_b_addr] <= i_b_wdata;
    if (i_a_we) begin
      if (i_a_addr[0]) r_mem[i_a_addr[7:1]][31:16] <= i_a_wdata;
      else             r_mem[i_a_addr[7:1]][15:0]  <= i_a_wdata;
    end
    r_b_q <= r_mem[i_b_addr];
  end

  // HPS read register is cleared so the data-to-HPS output starts at zero.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_a_q  <= '0;
      r_a_hi <= 1'b0;
    end else begin
      r_a_q  <= r_mem[i_a_addr[7:1]];
      r_a_hi <= i_a_addr[0];
    end
  end

  assign o_a_rdata = r_a_hi ? r_a_q[31:16] : r_a_q[15:0];
  assign o_b_rdata = r_b_q;

endmodule

// File: rtl/gba_bk_sync.sv
// Backup-RAM transfer engine: moves GBA save sectors between the HPS
// sector interface and the SDRAM save region.
// Ports:
//   clk_sys, reset             clock, synchronous active-high reset
//   bk_load, bk_save           rising edge starts a load / save
//   bk_sectors                 sector count, sampled at start
//   busy, loading              engine active / load in progress
//   sd_lba, sd_rd, sd_wr       HPS sector request
//   sd_ack, sd_buff_addr,      HPS transfer handshake and half-word buffer
//   sd_buff_dout, sd_buff_wr,  port
//   sd_buff_din
//   mem_addr, mem_dout,        SDRAM dword request (one outstanding,
//   mem_din, mem_req,          mem_req is a single-cycle pulse, mem_ack
//   mem_rnw, mem_ack           carries read data)
module gba_bk_sync
  import gba_bk_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'd0,
  parameter int unsigned MAX_SECTORS = 256
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        bk_load,
  input  logic        bk_save,
  input  logic [8:0]  bk_sectors,
  output logic        busy,
  output logic        loading,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [15:0] sd_buff_din,
  output logic [23:0] mem_addr,
  output logic [31:0] mem_dout,
  input  logic [31:0] mem_din,
  output logic        mem_req,
  output logic        mem_rnw,
  input  logic        mem_ack
);

  localparam logic [8:0]  MAX_CNT  = 9'(MAX_SECTORS);
  localparam logic [23:0] BASE24   = BASE_ADDR[23:0];
  localparam logic [6:0]  LAST_IDX = 7'(SECTOR_DWORDS - 1);

  bk_state_t   r_state, w_next;

  logic        r_load_d, r_save_d, r_ack_d;
  logic        r_op_load;
  logic [8:0]  r_count;
  logic [31:0] r_lba;
  logic [6:0]  r_idx;
  logic        r_pend;    // an SDRAM request is outstanding
  logic        r_fetch;   // buffer read for r_idx has landed in w_b_q
  logic        r_mem_req, r_mem_rnw;
  logic [23:0] r_mem_addr;
  logic [31:0] r_mem_dout;

  logic        w_load_edge, w_save_edge, w_start;
  logic        w_ack_fall, w_mem_last, w_last_sector;
  logic [8:0]  w_cnt;
  logic [23:0] w_mem_addr;
  logic        w_a_we, w_b_we;
  logic [31:0] w_b_q;

  assign w_load_edge   = bk_load & ~r_load_d;
  assign w_save_edge   = bk_save & ~r_save_d;
  assign w_start       = (r_state == ST_IDLE) && (w_load_edge || w_save_edge)
                         && (bk_sectors != 9'd0);
  assign w_cnt         = (bk_sectors > MAX_CNT) ? MAX_CNT : bk_sectors;
  assign w_ack_fall    = r_ack_d & ~sd_ack;
  assign w_mem_last    = r_pend & mem_ack & (r_idx == LAST_IDX);
  assign w_last_sector = (r_lba + 32'd1) == {23'd0, r_count};
  // Wraps modulo 2^24 by construction.
  assign w_mem_addr    = BASE24 + {1'b0, r_lba[15:0], 7'b0} + {17'b0, r_idx};

  assign w_a_we = (r_state == ST_LD_XFER) && sd_buff_wr;
  assign w_b_we = (r_state == ST_SV_FILL) && r_pend && mem_ack;

  bk_sector_buf u_buf (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .i_a_addr  (sd_buff_addr),
    .i_a_wdata (sd_buff_dout),
    .i_a_we    (w_a_we),
    .o_a_rdata (sd_buff_din),
    .i_b_addr  (r_idx),
    .i_b_wdata (mem_din),
    .i_b_we    (w_b_we),
    .o_b_rdata (w_b_q)
  );

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start) w_next = w_load_edge ? ST_LD_REQ : ST_SV_FILL;
      ST_LD_REQ:  if (sd_ack) w_next = ST_LD_XFER;
      ST_LD_XFER: if (w_ack_fall) w_next = ST_LD_COPY;
      ST_LD_COPY: if (w_mem_last) w_next = ST_NEXT;
      ST_SV_FILL: if (w_mem_last) w_next = ST_SV_REQ;
      ST_SV_REQ:  if (sd_ack) w_next = ST_SV_XFER;
      ST_SV_XFER: if (w_ack_fall) w_next = ST_NEXT;
      ST_NEXT:    begin
        if (w_last_sector) w_next = ST_IDLE;
        else               w_next = r_op_load ? ST_LD_REQ : ST_SV_FILL;
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy    = (r_state != ST_IDLE);
    loading = (r_state != ST_IDLE) && r_op_load;
    sd_rd   = (r_state == ST_LD_REQ);
    sd_wr   = (r_state == ST_SV_REQ);
  end

  // Datapath: edge detectors, counters and the SDRAM request sequencer
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_load_d   <= 1'b0;
      r_save_d   <= 1'b0;
      r_ack_d    <= 1'b0;
      r_op_load  <= 1'b0;
      r_count    <= '0;
      r_lba      <= '0;
      r_idx      <= '0;
      r_pend     <= 1'b0;
      r_fetch    <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_rnw  <= 1'b1;
      r_mem_addr <= '0;
      r_mem_dout <= '0;
    end else begin
      r_load_d  <= bk_load;
      r_save_d  <= bk_save;
      r_ack_d   <= sd_ack;
      r_mem_req <= 1'b0;

      if (w_start) begin
        r_op_load <= w_load_edge;
        r_count   <= w_cnt;
        r_lba     <= '0;
        r_idx     <= '0;
        r_pend    <= 1'b0;
        r_fetch   <= 1'b0;
      end

      if (r_state == ST_NEXT && !w_last_sector)
        r_lba <= r_lba + 32'd1;

      case (r_state)
        // Buffer read is registered: spend one cycle fetching the dword
        // before issuing its write, so mem_dout is the value for r_idx.
        ST_LD_COPY: begin
          if (r_pend) begin
            if (mem_ack) begin
              r_pend <= 1'b0;
              r_idx  <= r_idx + 7'd1;
            end
          end else if (!r_fetch) begin
            r_fetch <= 1'b1;
          end else begin
            r_fetch    <= 1'b0;
            r_mem_req  <= 1'b1;
            r_mem_rnw  <= 1'b0;
            r_mem_addr <= w_mem_addr;
            r_mem_dout <= w_b_q;
            r_pend     <= 1'b1;
          end
        end
        ST_SV_FILL: begin
          if (r_pend) begin
            if (mem_ack) begin
              r_pend <= 1'b0;
              r_idx  <= r_idx + 7'd1;
            end
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_rnw  <= 1'b1;
            r_mem_addr <= w_mem_addr;
            r_pend     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sd_lba   = r_lba;
  assign mem_req  = r_mem_req;
  assign mem_rnw  = r_mem_rnw;
  assign mem_addr = r_mem_addr;
  assign mem_dout = r_mem_dout;

endmodule

// File: tb/tb_gba_bk_sync.sv
module tb_gba_bk_sync;
  localparam logic [31:0] BASE = 32'd65536;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        bk_load = 1'b0, bk_save = 1'b0;
  logic [8:0]  bk_sectors = '0;
  logic        busy, loading, sd_rd, sd_wr;
  logic [31:0] sd_lba;
  logic        sd_ack = 1'b0;
  logic [7:0]  sd_buff_addr = '0;
  logic [15:0] sd_buff_dout = '0;
  logic        sd_buff_wr = 1'b0;
  logic [15:0] sd_buff_din;
  logic [23:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din = '0;
  logic        mem_req, mem_rnw;
  logic        mem_ack = 1'b0;

  gba_bk_sync #(.BASE_ADDR(BASE), .MAX_SECTORS(256)) dut (
    .clk_sys(clk_sys), .reset(reset), .bk_load(bk_load), .bk_save(bk_save),
    .bk_sectors(bk_sectors), .busy(busy), .loading(loading), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din), .mem_req(mem_req),
    .mem_rnw(mem_rnw), .mem_ack(mem_ack)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  // Behavioural models: SDRAM contents, save file image, captured save data
  logic [31:0] sdram [int];
  logic [15:0] file  [0:1023];
  logic [15:0] saved [0:1023];

  function automatic logic [31:0] sd_read(input int a);
    return sdram.exists(a) ? sdram[a] : (32'(a) ^ 32'hA5A5A5A5);
  endfunction

  // Expected SDRAM request stream
  int          exp_addr[$];
  bit          exp_rnw[$];
  logic [31:0] exp_data[$];

  task automatic push_load(input int s);
    for (int i = 0; i < 128; i++) begin
      exp_addr.push_back(int'(BASE) + s*128 + i);
      exp_rnw.push_back(1'b0);
      exp_data.push_back({file[s*256 + 2*i + 1], file[s*256 + 2*i]});
    end
  endtask

  task automatic push_save(input int s);
    for (int i = 0; i < 128; i++) begin
      exp_addr.push_back(int'(BASE) + s*128 + i);
      exp_rnw.push_back(1'b1);
      exp_data.push_back(32'd0);
    end
  endtask

  // SDRAM responder and protocol/stream compare, once per cycle
  bit rand_lat = 1'b0;
  int req_cnt = 0, wr_ack_cnt = 0, rd_rise = 0, wr_rise = 0, busy_cycles = 0;
  bit pend = 0, stale = 0, prev_req = 0, prev_rd = 0, prev_wr = 0;
  int cnt = 0, q_addr = 0;
  logic [31:0] q_dout = '0;
  logic q_rnw = 1'b1;

  always @(negedge clk_sys) begin
    if (sd_rd && !prev_rd) rd_rise++;
    if (sd_wr && !prev_wr) wr_rise++;
    prev_rd = sd_rd;
    prev_wr = sd_wr;
    if (busy) busy_cycles++;
    if (mem_req) begin
      req_cnt++;
      chk("mem_req_back_to_back", 32'(prev_req), 32'd0);
      chk("mem_req_while_outstanding", 32'(pend), 32'd0);
    end
    prev_req = mem_req;
    if (reset && pend) stale = 1'b1;
    if (mem_ack) begin
      mem_ack = 1'b0;
      pend = 1'b0;
      stale = 1'b0;
    end else if (pend) begin
      if (!stale) begin
        chk("mem_addr_hold", 32'(mem_addr), 32'(q_addr[23:0]));
        chk("mem_dout_hold", mem_dout, q_dout);
      end
      cnt--;
      if (cnt <= 0) begin
        mem_ack = 1'b1;
        if (q_rnw) mem_din = sd_read(q_addr);
        else begin
          sdram[q_addr] = q_dout;
          wr_ack_cnt++;
        end
      end
    end
    if (mem_req && !pend) begin
      q_addr = int'(mem_addr);
      q_dout = mem_dout;
      q_rnw  = mem_rnw;
      pend   = 1'b1;
      stale  = 1'b0;
      cnt    = rand_lat ? int'($urandom_range(20, 1)) : 2;
      if (exp_addr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_mem_req actual=%h required=none", mem_addr);
      end else begin
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
        chk("mem_rnw", 32'(mem_rnw), 32'(exp_rnw.pop_front()));
        if (!mem_rnw) chk("mem_dout", mem_dout, exp_data.pop_front());
        else void'(exp_data.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic pulse_start(input bit ld, input bit sv, input logic [8:0] n);
    bk_sectors = n;
    bk_load = ld;
    bk_save = sv;
    cyc(2);
    bk_load = 1'b0;
    bk_save = 1'b0;
  endtask

  // HPS side of one load sector: stream file words k into the buffer
  task automatic hps_load(input int s);
    int t = 0;
    while (!sd_rd && t < 5000) begin @(negedge clk_sys); t++; end
    if (!sd_rd) begin fail_now("wait_sd_rd"); return; end
    chk("load_sd_lba", sd_lba, 32'(s));
    sd_ack = 1'b1;
    @(negedge clk_sys);
    for (int k = 0; k < 256; k++) begin
      sd_buff_addr = 8'(k);
      sd_buff_dout = file[s*256 + k];
      sd_buff_wr = 1'b1;
      @(negedge clk_sys);
    end
    sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    sd_ack = 1'b0;
    @(negedge clk_sys);
    chk("sd_rd_cleared", 32'(sd_rd), 32'd0);
  endtask

  // HPS side of one save sector: read back 256 half-words, 1-cycle latency
  task automatic hps_save(input int s);
    int t = 0;
    logic [31:0] w;
    while (!sd_wr && t < 5000) begin @(negedge clk_sys); t++; end
    if (!sd_wr) begin fail_now("wait_sd_wr"); return; end
    chk("save_sd_lba", sd_lba, 32'(s));
    sd_ack = 1'b1;
    @(negedge clk_sys);
    for (int k = 0; k < 256; k++) begin
      sd_buff_addr = 8'(k);
      @(negedge clk_sys);
      saved[s*256 + k] = sd_buff_din;
      w = sd_read(int'(BASE) + s*128 + k/2);
      chk("save_word", 32'(sd_buff_din), 32'((k % 2) ? w[31:16] : w[15:0]));
    end
    sd_ack = 1'b0;
    cyc(2);
    chk("sd_wr_cleared", 32'(sd_wr), 32'd0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 8000) begin @(negedge clk_sys); t++; end
    if (busy) fail_now("wait_idle");
  endtask

  task automatic verify_sdram(input int nsec);
    int bad = 0;
    for (int i = 0; i < nsec*128; i++)
      if (sd_read(int'(BASE) + i) !== {file[2*i+1], file[2*i]}) bad++;
    chk("sdram_image_mismatches", 32'(bad), 32'd0);
  endtask

  initial begin
    int r0, w0, q0, b0, a0, t, bad;

    // Reset state
    cyc(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_loading", 32'(loading), 0);
    chk("rst_sd_rd", 32'(sd_rd), 0);
    chk("rst_sd_wr", 32'(sd_wr), 0);
    chk("rst_sd_lba", sd_lba, 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_rnw", 32'(mem_rnw), 1);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_dout", mem_dout, 0);
    chk("rst_sd_buff_din", 32'(sd_buff_din), 0);
    reset = 1'b0;
    cyc(2);

    // Load, 1 sector, word k = k
    for (int k = 0; k < 1024; k++) file[k] = 16'(k);
    push_load(0);
    a0 = wr_ack_cnt;
    pulse_start(1, 0, 1);
    chk("ld1_busy", 32'(busy), 1);
    chk("ld1_loading", 32'(loading), 1);
    hps_load(0);
    wait_idle();
    chk("ld1_write_count", 32'(wr_ack_cnt - a0), 128);
    chk("ld1_queue_drained", 32'(exp_addr.size()), 0);
    chk("ld1_dword0", sd_read(65536), 32'h00010000);
    chk("ld1_dword127", sd_read(65663), 32'h00FF00FE);
    chk("ld1_loading_end", 32'(loading), 0);

    // Save, 2 sectors, SDRAM = addr ^ A5A5A5A5
    for (int a = 65536; a < 65792; a++) sdram[a] = 32'(a) ^ 32'hA5A5A5A5;
    push_save(0);
    push_save(1);
    pulse_start(0, 1, 2);
    chk("sv2_busy", 32'(busy), 1);
    chk("sv2_loading", 32'(loading), 0);
    hps_save(0);
    hps_save(1);
    wait_idle();
    chk("sv2_queue_drained", 32'(exp_addr.size()), 0);
    chk("sv2_word1_literal", 32'(saved[1]), 32'h0000A5A4);

    // Simultaneous edges: load wins, edges while busy are ignored
    for (int k = 0; k < 256; k++) file[k] = 16'(k) ^ 16'h5A00;
    push_load(0);
    r0 = rd_rise; w0 = wr_rise;
    pulse_start(1, 1, 1);
    chk("both_loading", 32'(loading), 1);
    cyc(3);
    pulse_start(1, 1, 1);
    hps_load(0);
    wait_idle();
    cyc(40);
    chk("both_rd_count", 32'(rd_rise - r0), 1);
    chk("both_wr_count", 32'(wr_rise - w0), 0);
    chk("both_busy_end", 32'(busy), 0);
    chk("both_queue_drained", 32'(exp_addr.size()), 0);
    verify_sdram(1);

    // Zero sector count
    q0 = req_cnt; b0 = busy_cycles; r0 = rd_rise; w0 = wr_rise;
    pulse_start(1, 0, 0);
    cyc(2);
    pulse_start(0, 1, 0);
    cyc(20);
    chk("zero_busy_cycles", 32'(busy_cycles - b0), 0);
    chk("zero_mem_req", 32'(req_cnt - q0), 0);
    chk("zero_sd_rd", 32'(rd_rise - r0), 0);
    chk("zero_sd_wr", 32'(wr_rise - w0), 0);

    // Reset mid-copy at dword 40
    for (int k = 0; k < 256; k++) file[k] = 16'($urandom);
    push_load(0);
    pulse_start(1, 0, 1);
    hps_load(0);
    q0 = req_cnt - exp_addr.size() + 128 - 128;
    q0 = req_cnt;
    t = 0;
    // q0 counted before any copy request of this sector; i = 40 is the 41st
    while ((req_cnt - q0) < 41 && t < 5000) begin @(negedge clk_sys); t++; end
    if ((req_cnt - q0) < 41) fail_now("wait_copy_40");
    reset = 1'b1;
    @(negedge clk_sys);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_sd_rd", 32'(sd_rd), 0);
    chk("rst_mid_mem_req", 32'(mem_req), 0);
    @(negedge clk_sys);
    reset = 1'b0;
    exp_addr.delete(); exp_rnw.delete(); exp_data.delete();
    q0 = req_cnt;
    cyc(60);
    chk("rst_mid_no_req", 32'(req_cnt - q0), 0);
    chk("rst_mid_idle", 32'(busy), 0);
    for (int k = 0; k < 256; k++) file[k] = 16'($urandom);
    push_load(0);
    pulse_start(1, 0, 1);
    hps_load(0);
    wait_idle();
    chk("rst_reload_queue_drained", 32'(exp_addr.size()), 0);
    verify_sdram(1);

    // Random SDRAM latency, 4-sector load then save round trip
    rand_lat = 1'b1;
    for (int k = 0; k < 1024; k++) file[k] = 16'($urandom);
    for (int s = 0; s < 4; s++) push_load(s);
    pulse_start(1, 0, 4);
    for (int s = 0; s < 4; s++) hps_load(s);
    wait_idle();
    chk("rnd_load_queue_drained", 32'(exp_addr.size()), 0);
    verify_sdram(4);
    for (int s = 0; s < 4; s++) push_save(s);
    pulse_start(0, 1, 4);
    for (int s = 0; s < 4; s++) hps_save(s);
    wait_idle();
    chk("rnd_save_queue_drained", 32'(exp_addr.size()), 0);
    bad = 0;
    for (int k = 0; k < 1024; k++) if (saved[k] !== file[k]) bad++;
    chk("rnd_roundtrip_mismatches", 32'(bad), 0);
    chk("rnd_busy_end", 32'(busy), 0);

    cyc(30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
